// File: rtl/apb_periph_router.sv
// ============================================================================
// apb_periph_router : APB 1-to-N address-window router with timeout and
//                     sticky first-error record
// Revision 1.0
// ============================================================================
`default_nettype none

module apb_periph_router #(
  parameter int                        NB_MASTER      = 10,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [APB_ADDR_WIDTH-1:0]           s_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]           s_pwdata_i,
  input  logic                                s_pwrite_i,
  input  logic                                s_psel_i,
  input  logic                                s_penable_i,
  output logic [APB_DATA_WIDTH-1:0]           s_prdata_o,
  output logic                                s_pready_o,
  output logic                                s_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
  output logic                                m_pwrite_o,
  output logic                                m_penable_o,
  output logic [NB_MASTER-1:0]                m_psel_o,
  input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_MASTER-1:0]                m_pready_i,
  input  logic [NB_MASTER-1:0]                m_pslverr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                err_valid_o,
  output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
  output logic [1:0]                          err_code_o,
  input  logic                                err_clr_i
);

  localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_MISS    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SLAVE   = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FWD_SETUP  = 2'd1,
    FWD_ACCESS = 2'd2,
    RESP       = 2'd3
  } state_t;

  state_t state, state_next;

  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      write_q;
  logic                      hit_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CNT_W-1:0]          cnt;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      slverr_q;

  logic [NB_MASTER-1:0]      in_win;
  logic [APB_DATA_WIDTH-1:0] prdata_w [NB_MASTER];

  logic                      accept;
  logic                      dec_hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      sel_pready;
  logic                      sel_slverr;
  logic [APB_DATA_WIDTH-1:0] sel_rdata;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      timeout_hit;
  logic                      err_evt;
  logic [1:0]                err_code_next;

  generate
    for (genvar k = 0; k < NB_MASTER; k++) begin : g_win
      assign in_win[k]   = (s_paddr_i >= start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                           (s_paddr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
      assign prdata_w[k] = m_prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end
  endgenerate

  assign accept      = (state == IDLE) && s_psel_i && !s_penable_i;
  assign sel_pready  = m_pready_i[idx_q];
  assign sel_slverr  = m_pslverr_i[idx_q];
  assign sel_rdata   = prdata_w[idx_q];
  assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !sel_pready && (cnt_inc == TO_MAX);

  // Scanning from the top down leaves the lowest matching window selected.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = NB_MASTER - 1; k >= 0; k--) begin
      if (in_win[k]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // A miss spends its FWD_SETUP cycle with no select raised, so the error
  // response lands where a zero-wait slave's ACCESS cycle would.
  always_comb begin
    state_next    = state;
    err_evt       = 1'b0;
    err_code_next = 2'b00;
    case (state)
      IDLE:       if (accept) state_next = FWD_SETUP;
      FWD_SETUP: begin
        state_next = hit_q ? FWD_ACCESS : RESP;
        if (!hit_q) begin
          err_evt       = 1'b1;
          err_code_next = ERR_MISS;
        end
      end
      FWD_ACCESS: begin
        if (sel_pready) begin
          state_next = RESP;
          if (sel_slverr) begin
            err_evt       = 1'b1;
            err_code_next = ERR_SLAVE;
          end
        end else if (timeout_hit) begin
          state_next    = RESP;
          err_evt       = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end
      end
      RESP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= s_paddr_i;
        wdata_q <= s_pwdata_i;
        write_q <= s_pwrite_i;
        hit_q   <= dec_hit;
        idx_q   <= dec_idx;
      end
      case (state)
        FWD_SETUP: begin
          cnt <= '0;
          if (!hit_q) begin
            rdata_q  <= ERR_DATA;
            slverr_q <= 1'b1;
          end
        end
        FWD_ACCESS: begin
          if (sel_pready) begin
            rdata_q  <= sel_rdata;
            slverr_q <= sel_slverr;
          end else begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
              rdata_q  <= ERR_DATA;
              slverr_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A clear in the same cycle as a new error lets the new error in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_code_o  <= 2'b00;
    end else begin
      if (err_clr_i) err_valid_o <= 1'b0;
      if (err_evt && (!err_valid_o || err_clr_i)) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= addr_q;
        err_code_o  <= err_code_next;
      end
    end
  end

  assign m_paddr_o   = addr_q;
  assign m_pwdata_o  = wdata_q;
  assign m_pwrite_o  = write_q;
  assign m_penable_o = (state == FWD_ACCESS);
  assign m_psel_o    = (((state == FWD_SETUP) || (state == FWD_ACCESS)) && hit_q) ?
                       (NB_MASTER'(1) << idx_q) : '0;
  assign s_pready_o  = (state == RESP);
  assign s_prdata_o  = rdata_q;
  assign s_pslverr_o = slverr_q;

endmodule

`default_nettype wire
